// File: rtl/framebuffer_fill.sv
// -----------------------------------------------------------------------------
// framebuffer_fill
//
// A video framebuffer that runs on a single pixel clock. It stores a
// RES_W x RES_H image at COLOR_DEPTH bits per pixel in a simple dual-port RAM.
//
// Scan side (never stalls, independent of the host side):
//   PX, PY, ON_SCREEN -> PIXEL_OUT. The pipeline is a fixed 2 cycles, and each
//   image pixel covers 2^SCALE_SHIFT screen pixels along each axis. Any scan
//   position outside the active area or outside the image returns black (0).
//
// Host side:
//   X_POS, Y_POS, COLOR, WRITE -> ACK, ERR   single-pixel write, level handshake
//   FILL, COLOR                -> BUSY       paints the whole image, 1 px/clk
//   FSM_STATE                                current host FSM state (0 idle,
//                                            1 filling)
//
// Handshake: WRITE is a level request, sampled only while the FSM is idle
// and ACK is low. When a request is accepted or dropped, ACK pulses for
// exactly one cycle; ERR pulses with it if the position was out of range.
// The host drops WRITE in the cycle it sees ACK. If WRITE is still high one
// cycle after ACK, it counts as a new request. FILL has priority over WRITE.
//
// PIXEL_OUT bit mapping for depth 3: bit0 = R, bit1 = G, bit2 = B.
// -----------------------------------------------------------------------------
module framebuffer_fill #(
  parameter int RES_W       = 200,
  parameter int RES_H       = 150,
  parameter int COLOR_DEPTH = 3,
  parameter int SCALE_SHIFT = 2,
  parameter int XW          = 8,
  parameter int YW          = 8
) (
  input  logic                   PIXEL_CLOCK,
  input  logic                   RESET,
  input  logic [10:0]            PX,
  input  logic [9:0]             PY,
  input  logic                   ON_SCREEN,
  output logic [COLOR_DEPTH-1:0] PIXEL_OUT,
  input  logic [XW-1:0]          X_POS,
  input  logic [YW-1:0]          Y_POS,
  input  logic [COLOR_DEPTH-1:0] COLOR,
  input  logic                   WRITE,
  input  logic                   FILL,
  output logic                   ACK,
  output logic                   ERR,
  output logic                   BUSY,
  output logic                   FSM_STATE
);

  localparam int NPIX   = RES_W * RES_H;
  localparam int ADDR_W = $clog2(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(RES_W);

  typedef enum logic {
    IDLE    = 1'b0,
    FILLING = 1'b1
  } state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        fill_cnt;
  logic [COLOR_DEPTH-1:0]   fill_color;

  // Pixel storage. Reset does not touch it, so its power-up contents are
  // undefined.
  logic [COLOR_DEPTH-1:0]   mem [0:NPIX-1];

  // ---------------------------------------------------------------------------
  // Host write decode
  // ---------------------------------------------------------------------------
  logic                     host_in_range;
  logic                     write_req;
  logic [ADDR_W-1:0]        host_addr;

  assign host_in_range = (32'(X_POS) < RES_W) && (32'(Y_POS) < RES_H);
  // While ACK is high, the request it answers is still on the bus, so it is
  // not sampled again.
  assign write_req     = (state == IDLE) && WRITE && !FILL && !ACK;
  assign host_addr     = ADDR_W'(Y_POS) * ROW_STEP + ADDR_W'(X_POS);

  // ---------------------------------------------------------------------------
  // RAM write port: the fill engine owns it while filling, the host otherwise
  // ---------------------------------------------------------------------------
  logic                     ram_we;
  logic [ADDR_W-1:0]        ram_waddr;
  logic [COLOR_DEPTH-1:0]   ram_wdata;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = host_addr;
    ram_wdata = COLOR;
    if (state == FILLING) begin
      ram_we    = 1'b1;
      ram_waddr = fill_cnt;
      ram_wdata = fill_color;
    end else if (write_req && host_in_range) begin
      ram_we    = 1'b1;
    end
  end

  always_ff @(posedge PIXEL_CLOCK) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Host FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      fill_cnt   <= '0;
      fill_color <= '0;
      ACK        <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (FILL) begin
            state      <= FILLING;
            fill_color <= COLOR;
            fill_cnt   <= '0;
            BUSY       <= 1'b1;
          end else if (write_req) begin
            ACK <= 1'b1;
            ERR <= !host_in_range;
          end
        end
        FILLING: begin
          // The last address is written on this edge. BUSY drops with the
          // state change, so it stays high for exactly NPIX cycles.
          if (fill_cnt == LAST_ADDR) begin
            state    <= IDLE;
            fill_cnt <= '0;
            BUSY     <= 1'b0;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  assign FSM_STATE = state;

  // ---------------------------------------------------------------------------
  // Scan pipeline
  //   stage 1: scaled address and in-range flag
  //   stage 2: RAM read, masked to black when out of range
  // The RAM read uses the old data when it hits the same address as a write
  // on the same edge (read-first).
  // ---------------------------------------------------------------------------
  logic [10:0]              sx;
  logic [9:0]               sy;
  logic                     scan_in_range;
  logic [ADDR_W-1:0]        scan_addr;
  logic [ADDR_W-1:0]        rd_addr;
  logic                     rd_valid;

  assign sx            = PX >> SCALE_SHIFT;
  assign sy            = PY >> SCALE_SHIFT;
  assign scan_in_range = ON_SCREEN && (32'(sx) < RES_W) && (32'(sy) < RES_H);
  assign scan_addr     = ADDR_W'(sy) * ROW_STEP + ADDR_W'(sx);

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_addr   <= '0;
      rd_valid  <= 1'b0;
      PIXEL_OUT <= '0;
    end else begin
      rd_addr   <= scan_addr;
      rd_valid  <= scan_in_range;
      PIXEL_OUT <= rd_valid ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_framebuffer_fill.sv
// -----------------------------------------------------------------------------
// Testbench for framebuffer_fill. A behavioural image model (a pixel array
// plus a "known" mask, because the RAM does not reset) gives the expected
// scan colours. The host port is driven through tasks, and random scans are
// checked through an expected queue.
// -----------------------------------------------------------------------------
module tb_framebuffer_fill;

  localparam int RES_W       = 200;
  localparam int RES_H       = 150;
  localparam int COLOR_DEPTH = 3;
  localparam int SCALE_SHIFT = 2;
  localparam int XW          = 8;
  localparam int YW          = 8;
  localparam int NPIX        = RES_W * RES_H;
  localparam int SCALE       = 2 ** SCALE_SHIFT;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                   clk = 1'b0;
  logic                   RESET;
  logic [10:0]            PX;
  logic [9:0]             PY;
  logic                   ON_SCREEN;
  logic [COLOR_DEPTH-1:0] PIXEL_OUT;
  logic [XW-1:0]          X_POS;
  logic [YW-1:0]          Y_POS;
  logic [COLOR_DEPTH-1:0] COLOR;
  logic                   WRITE;
  logic                   FILL;
  logic                   ACK;
  logic                   ERR;
  logic                   BUSY;
  logic                   FSM_STATE;

  always #5 clk = ~clk;

  framebuffer_fill #(
    .RES_W(RES_W), .RES_H(RES_H), .COLOR_DEPTH(COLOR_DEPTH),
    .SCALE_SHIFT(SCALE_SHIFT), .XW(XW), .YW(YW)
  ) dut (
    .PIXEL_CLOCK(clk),
    .RESET(RESET),
    .PX(PX),
    .PY(PY),
    .ON_SCREEN(ON_SCREEN),
    .PIXEL_OUT(PIXEL_OUT),
    .X_POS(X_POS),
    .Y_POS(Y_POS),
    .COLOR(COLOR),
    .WRITE(WRITE),
    .FILL(FILL),
    .ACK(ACK),
    .ERR(ERR),
    .BUSY(BUSY),
    .FSM_STATE(FSM_STATE)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int                     total  = 0;
  int                     passed = 0;
  logic [COLOR_DEPTH-1:0] ref_mem [NPIX];
  bit                     known   [NPIX];
  logic [COLOR_DEPTH-1:0] exp_q [$];
  bit                     chk_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected colour at a scan position; -1 when the pixel was never written.
  function automatic int model_pix(input int px, input int py, input bit on);
    int ix = px / SCALE;
    int iy = py / SCALE;
    if (!on || ix >= RES_W || iy >= RES_H) return 0;
    if (!known[iy * RES_W + ix]) return -1;
    return int'(ref_mem[iy * RES_W + ix]);
  endfunction

  function automatic void model_write(input int x, input int y, input int c);
    if (x < RES_W && y < RES_H) begin
      ref_mem[y * RES_W + x] = COLOR_DEPTH'(c);
      known[y * RES_W + x]   = 1'b1;
    end
  endfunction

  function automatic void model_fill(input int c, input int upto);
    for (int a = 0; a < upto; a++) begin
      ref_mem[a] = COLOR_DEPTH'(c);
      known[a]   = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_one(input int px, input int py, input bit on, input string tag);
    int e;
    PX        = 11'(px);
    PY        = 10'(py);
    ON_SCREEN = on;
    step();
    step();
    e = model_pix(px, py, on);
    if (e >= 0) chk(tag, 32'(PIXEL_OUT), 32'(e));
  endtask

  // Sends one new random scan position every cycle and checks each result
  // two cycles later.
  task automatic scan_stream(input int n);
    int px, py, e;
    bit on;
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        e = int'(exp_q.pop_front());
        if (chk_q.pop_front()) chk("scan_stream", 32'(PIXEL_OUT), 32'(e));
      end
      if (i < n) begin
        px = int'($urandom_range(0, 899));
        py = int'($urandom_range(0, 639));
        on = ($urandom_range(0, 7) != 0);
        PX        = 11'(px);
        PY        = 10'(py);
        ON_SCREEN = on;
        e = model_pix(px, py, on);
        exp_q.push_back(COLOR_DEPTH'(e < 0 ? 0 : e));
        chk_q.push_back(e >= 0);
      end else begin
        ON_SCREEN = 1'b0;
      end
      step();
    end
  endtask

  task automatic host_write(input int x, input int y, input int c);
    int n = 0;
    bit oor = !(x < RES_W && y < RES_H);
    X_POS = XW'(x);
    Y_POS = YW'(y);
    COLOR = COLOR_DEPTH'(c);
    WRITE = 1'b1;
    do begin
      step();
      n++;
    end while (ACK !== 1'b1 && n < 8);
    chk("write_ack_latency", 32'(n), 32'd1);
    chk("write_err", 32'(ERR), 32'(oor));
    WRITE = 1'b0;
    step();
    chk("ack_single_pulse", 32'(ACK), 32'd0);
    model_write(x, y, c);
  endtask

  // Runs a complete fill. Optionally a write is raised in the same cycle as
  // FILL and held for the whole fill; it has to land once the fill is done.
  task automatic run_fill(input int c, input bit with_write, input int wx, input int wy,
                          input int wc);
    int cycles = 0;
    int n = 0;
    bit ack_seen = 1'b0;
    COLOR = COLOR_DEPTH'(c);
    FILL  = 1'b1;
    WRITE = with_write;
    X_POS = XW'(wx);
    Y_POS = YW'(wy);
    step();
    FILL = 1'b0;
    chk("busy_rise", 32'(BUSY), 32'd1);
    if (with_write) COLOR = COLOR_DEPTH'(wc);
    while (BUSY === 1'b1 && cycles < NPIX + 100) begin
      cycles++;
      if (ACK === 1'b1) ack_seen = 1'b1;
      if (!with_write) COLOR = COLOR_DEPTH'($urandom);
      FILL = ($urandom_range(0, 15) == 0);
      step();
    end
    FILL  = 1'b0;
    COLOR = COLOR_DEPTH'(with_write ? wc : c);
    chk("fill_busy_cycles", 32'(cycles), 32'(NPIX));
    chk("no_ack_during_fill", 32'(ack_seen), 32'd0);
    model_fill(c, NPIX);
    if (with_write) begin
      do begin
        step();
        n++;
      end while (ACK !== 1'b1 && n < 4);
      chk("post_fill_ack_latency", 32'(n), 32'd1);
      chk("post_fill_err", 32'(ERR), 32'd0);
      WRITE = 1'b0;
      step();
      model_write(wx, wy, wc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    RESET = 1'b1;
    PX = '0; PY = '0; ON_SCREEN = 1'b0;
    X_POS = '0; Y_POS = '0; COLOR = '0; WRITE = 1'b0; FILL = 1'b0;
    for (int a = 0; a < NPIX; a++) known[a] = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_pixel_out", 32'(PIXEL_OUT), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_state", 32'(FSM_STATE), 32'd0);
    RESET = 1'b0;
    step();

    // Fill with blue, then check random scans against it
    run_fill(3'b100, 1'b0, 0, 0, 0);
    chk("busy_low_after_fill", 32'(BUSY), 32'd0);
    scan_stream(150);

    // Write and read back; the neighbouring pixel keeps the fill colour
    host_write(10, 10, 3'b001);
    for (int y = 40; y < 44; y++)
      for (int x = 40; x < 44; x++)
        scan_one(x, y, 1'b1, "readback_block");
    scan_one(44, 40, 1'b1, "readback_neighbour");

    // Read-first: a scan read and a write to the same address on the same edge
    PX = 11'd40; PY = 10'd40; ON_SCREEN = 1'b1;
    step();
    X_POS = 8'd10; Y_POS = 8'd10; COLOR = 3'b110; WRITE = 1'b1;
    step();
    chk("rf_ack", 32'(ACK), 32'd1);
    chk("rf_old_data", 32'(PIXEL_OUT), 32'b001);
    WRITE = 1'b0;
    step();
    chk("rf_new_data", 32'(PIXEL_OUT), 32'b110);
    model_write(10, 10, 3'b110);

    // Range checks: writes must not alias onto other pixels
    host_write(200, 5, 3'b011);
    host_write(7, 150, 3'b011);
    scan_one(0, 24, 1'b1, "no_alias_x");
    scan_one(800, 20, 1'b1, "scan_px_oob");
    scan_one(20, 600, 1'b1, "scan_py_oob");
    scan_one(40, 40, 1'b0, "scan_off_screen");

    // Random writes, some of them out of range, then random scans
    for (int i = 0; i < 20; i++)
      host_write(int'($urandom_range(0, 209)), int'($urandom_range(0, 159)),
                 int'($urandom_range(0, 7)));
    scan_stream(200);

    // Contention: FILL and WRITE together; the write lands after the fill
    run_fill(3'b010, 1'b1, 30, 20, 3'b101);
    scan_one(120, 80, 1'b1, "contention_write_on_top");
    scan_one(124, 80, 1'b1, "contention_fill_neighbour");
    scan_stream(100);

    // Reset at fill cycle 1000
    COLOR = 3'b111;
    FILL  = 1'b1;
    step();
    FILL = 1'b0;
    PX = '0; PY = '0; ON_SCREEN = 1'b1;
    for (int i = 0; i < 1000; i++) step();
    chk("pix_before_reset", 32'(PIXEL_OUT), 32'b111);
    chk("busy_before_reset", 32'(BUSY), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    chk("midfill_rst_busy", 32'(BUSY), 32'd0);
    chk("midfill_rst_pixel", 32'(PIXEL_OUT), 32'd0);
    chk("midfill_rst_ack", 32'(ACK), 32'd0);
    chk("midfill_rst_err", 32'(ERR), 32'd0);
    chk("midfill_rst_state", 32'(FSM_STATE), 32'd0);
    model_fill(3'b111, 1000);
    step();
    step();
    RESET = 1'b0;
    step();
    chk("busy_stays_low", 32'(BUSY), 32'd0);
    scan_one(199 * SCALE, 4 * SCALE, 1'b1, "addr_999_filled");
    scan_one(0, 5 * SCALE, 1'b1, "addr_1000_prior");
    scan_one(0, 0, 1'b0, "off_screen_forces_black");
    scan_stream(200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
